// File: rtl/uart_tx_mmio_pkg.sv
// Shared register map, STATUS layout and transmitter state encoding for uart_tx_mmio.
// Register offsets are word indices taken from address[3:2].
package uart_tx_mmio_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STATUS_OVF_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth, pointers wrap naturally.
// Latency: pushed entry visible on pop_dat the cycle after the push edge.
// Backpressure: push dropped when full unless a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_vld && !empty;
  assign do_push = push_vld && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes, serialised LSB first on tx.
// Latency: store committed at edge N into an idle empty block drives the start bit after edge N+1.
// Backpressure: none on the bus; a store to a full FIFO with no same-edge pop is dropped and flags overflow.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  inout  logic [31:0] data,
  input  logic        data_rw,
  input  logic [31:0] address,
  output logic        tx,
  output logic        tx_idle
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        sel;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  reg_off;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic        txdata_wr;
  logic        status_wr;
  logic        div_wr;

  assign sel       = (address[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = address[3:2];
  assign wr_en     = sel && data_rw;
  assign rd_en     = sel && !data_rw;
  assign wr_dat    = data;
  assign txdata_wr = wr_en && (reg_off == REG_TXDATA);
  assign status_wr = wr_en && (reg_off == REG_STATUS);
  assign div_wr    = wr_en && (reg_off == REG_DIV);

  logic unused_bits;
  assign unused_bits = ^{address[1:0], wr_dat[31:16]};

  // A DIV store landing on a bit boundary must be the value reloaded there.
  logic [15:0] div_q;
  logic [15:0] div_eff;
  assign div_eff = div_wr ? wr_dat[15:0] : div_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIV_RESET;
    end else if (div_wr) begin
      div_q <= wr_dat[15:0];
    end
  end

  logic          fifo_pop;
  logic [7:0]    fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (txdata_wr),
    .push_dat (wr_dat[7:0]),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (txdata_wr && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end else if (status_wr && wr_dat[STATUS_OVF_BIT]) begin
      overflow_q <= 1'b0;
    end
  end

  tx_state_e  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          baud_d   = div_eff;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_q == 16'd0) begin
          baud_d  = div_eff;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (baud_q == 16'd0) begin
          baud_d  = div_eff;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          baud_d = div_eff;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dat;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_idle = fifo_empty && (state_q == ST_IDLE);

  status_t status;

  always_comb begin
    status          = '0;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.busy     = (state_q != ST_IDLE);
    status.overflow = overflow_q;
    status.count    = 8'(fifo_count);
  end

  always_comb begin
    rd_dat = '0;
    case (reg_off)
      REG_TXDATA: rd_dat = '0;
      REG_STATUS: rd_dat = status;
      REG_DIV:    rd_dat = {16'd0, div_q};
      REG_RSVD:   rd_dat = '0;
      default:    rd_dat = '0;
    endcase
  end

  assign data = rd_en ? rd_dat : 'z;

endmodule
